// File: rtl/fc2_inference_sequencer_if.sv
// Handshake/bus bundle for fc2_inference_sequencer: upstream activations, layer link, result port.
// master is the sequencer's view; slave is the surrounding environment's view.
interface fc2_inference_sequencer_if #(
  parameter int unsigned DW = 16
) ();
  logic [DW-1:0] act_data;
  logic          act_valid;
  logic          act_ready;
  logic          fc_start;
  logic [DW-1:0] fc_in_data;
  logic          fc_in_valid;
  logic [DW-1:0] fc_out_data;
  logic          fc_out_valid;
  logic          fc_done;
  logic [3:0]    class_id;
  logic [DW-1:0] class_score;
  logic          class_valid;
  logic          class_ready;

  modport master (
    input  act_data, act_valid, fc_out_data, fc_out_valid, fc_done, class_ready,
    output act_ready, fc_start, fc_in_data, fc_in_valid, class_id, class_score, class_valid
  );

  modport slave (
    output act_data, act_valid, fc_out_data, fc_out_valid, fc_done, class_ready,
    input  act_ready, fc_start, fc_in_data, fc_in_valid, class_id, class_score, class_valid
  );
endinterface

// File: rtl/fc2_inference_sequencer.sv
// Buffers N_IN activations, replays them into the 32->10 output layer, argmaxes the logits.
// Optional FC2_WATCHDOG_EN adds a WAIT-state timeout that forces a result and sets err.
module fc2_inference_sequencer #(
  parameter int unsigned N_IN      = 32,
  parameter int unsigned N_OUT     = 10,
  parameter int unsigned DW        = 16,
  parameter int unsigned WD_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  fc2_inference_sequencer_if.master    bus,
  output logic                         busy,
  output logic                         err
);
  localparam int unsigned IdxW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned PtrW = $clog2(N_IN + 1);
  localparam int unsigned CntW = $clog2(N_OUT + 1) + 1;
  localparam logic [PtrW-1:0] LastWr  = PtrW'(N_IN - 1);
  localparam logic [IdxW-1:0] LastRd  = IdxW'(N_IN - 1);
  localparam logic [CntW-1:0] NOutCnt = CntW'(N_OUT);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StWait, StResult} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        buf_cnt_q, buf_cnt_d;
  logic [IdxW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]          act_buf [N_IN];
  logic [CntW-1:0]        logit_cnt_q, logit_cnt_d;
  logic [3:0]             best_idx_q, best_idx_d;
  logic signed [DW-1:0]   best_val_q, best_val_d;
  logic                   fc_start_q, fc_start_d;
  logic                   fc_in_valid_q, fc_in_valid_d;
  logic [DW-1:0]          fc_in_data_q, fc_in_data_d;
  logic                   err_q, err_d;
  logic                   act_hs;
`ifdef FC2_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WD_CYCLES - 1);
  logic [WdW-1:0]         wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    buf_cnt_d     = buf_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    logit_cnt_d   = logit_cnt_q;
    best_idx_d    = best_idx_q;
    best_val_d    = best_val_q;
    fc_start_d    = 1'b0;
    fc_in_valid_d = 1'b0;
    fc_in_data_d  = '0;
    err_d         = err_q;
    act_hs        = 1'b0;
`ifdef FC2_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.act_valid) begin
          act_hs    = 1'b1;
          buf_cnt_d = buf_cnt_q + 1'b1;
          if (buf_cnt_q == LastWr) begin
            state_d       = StLoad;
            rd_ptr_d      = '0;
            fc_start_d    = 1'b1;
            fc_in_valid_d = 1'b1;
            // word 0 may be the one arriving this very edge when N_IN == 1
            fc_in_data_d  = (buf_cnt_q == '0) ? bus.act_data : act_buf[0];
          end
        end
      end
      StLoad: begin
        fc_start_d = 1'b1;
        if (rd_ptr_q == LastRd) begin
          state_d = StArm;
        end else begin
          rd_ptr_d      = rd_ptr_q + 1'b1;
          fc_in_valid_d = 1'b1;
          fc_in_data_d  = act_buf[rd_ptr_d];
        end
      end
      StArm: begin
        state_d     = StWait;
        logit_cnt_d = '0;
        best_idx_d  = '0;
        best_val_d  = '0;
`ifdef FC2_WATCHDOG_EN
        wd_cnt_d    = '0;
`endif
      end
      StWait: begin
        if (bus.fc_out_valid) begin
          // strict compare keeps the lowest index on ties; surplus logits only count
          if (logit_cnt_q < NOutCnt &&
              (logit_cnt_q == '0 || $signed(bus.fc_out_data) > best_val_q)) begin
            best_idx_d = logit_cnt_q[3:0];
            best_val_d = $signed(bus.fc_out_data);
          end
          if (logit_cnt_q != '1) logit_cnt_d = logit_cnt_q + 1'b1;
        end
        if (bus.fc_done) begin
          state_d = StResult;
          if (logit_cnt_d != NOutCnt) err_d = 1'b1;
        end
`ifdef FC2_WATCHDOG_EN
        else if (wd_cnt_q == WdLast) begin
          state_d = StResult;
          err_d   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      StResult: begin
        if (bus.class_ready) begin
          state_d   = StIdle;
          buf_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      buf_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      logit_cnt_q   <= '0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      fc_start_q    <= 1'b0;
      fc_in_valid_q <= 1'b0;
      fc_in_data_q  <= '0;
      err_q         <= 1'b0;
`ifdef FC2_WATCHDOG_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      buf_cnt_q     <= buf_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      logit_cnt_q   <= logit_cnt_d;
      best_idx_q    <= best_idx_d;
      best_val_q    <= best_val_d;
      fc_start_q    <= fc_start_d;
      fc_in_valid_q <= fc_in_valid_d;
      fc_in_data_q  <= fc_in_data_d;
      err_q         <= err_d;
`ifdef FC2_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  // Activation storage needs no reset; buf_cnt alone defines what is valid.
  always_ff @(posedge clk) begin
    if (act_hs) act_buf[buf_cnt_q[IdxW-1:0]] <= bus.act_data;
  end

  assign bus.act_ready   = (state_q == StIdle);
  assign bus.fc_start    = fc_start_q;
  assign bus.fc_in_valid = fc_in_valid_q;
  assign bus.fc_in_data  = fc_in_data_q;
  assign bus.class_id    = best_idx_q;
  assign bus.class_score = best_val_q;
  assign bus.class_valid = (state_q == StResult);
  assign busy            = (state_q != StIdle);
  assign err             = err_q;
endmodule

// File: tb/tb_fc2_inference_sequencer.sv
// Directed self-checking bench for fc2_inference_sequencer; the bench plays the layer itself.
module tb_fc2_inference_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic busy, err;
  int   n_pass = 0;
  int   n_chk  = 0;
  logic [15:0] lg [10];

  fc2_inference_sequencer_if #(.DW(16)) bus ();

  fc2_inference_sequencer #(
    .N_IN(32), .N_OUT(10), .DW(16), .WD_CYCLES(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_state();
    chk("rst_act_ready", 32'(bus.act_ready), 32'd1);
    chk("rst_fc", {bus.fc_start, bus.fc_in_valid, bus.fc_in_data}, 32'd0);
    chk("rst_class", {bus.class_valid, bus.class_id, bus.class_score}, 32'd0);
    chk("rst_busy_err", {busy, err}, 32'd0);
  endtask

  task automatic send_frame(input logic [15:0] base);
    for (int i = 0; i < 32; i++) begin
      bus.act_valid = 1'b1;
      bus.act_data  = base + 16'(i);
      tick();
    end
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    chk("load_entry", {bus.act_ready, busy}, 32'b01);
  endtask

  task automatic replay_check(input logic [15:0] base);
    for (int k = 0; k < 32; k++) begin
      chk("replay", {bus.fc_start, bus.fc_in_valid, bus.fc_in_data}, {14'd0, 2'b11, base + 16'(k)});
      tick();
    end
    chk("arm", {bus.fc_start, bus.fc_in_valid}, 32'b10);
    tick();
    chk("wait_start_low", {bus.fc_start, bus.fc_in_valid, busy}, 32'b001);
  endtask

  task automatic play(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      bus.fc_out_valid = 1'b1;
      bus.fc_out_data  = lg[i];
      bus.fc_done      = done_last && (i == n - 1);
      tick();
      bus.fc_out_valid = 1'b0;
      bus.fc_done      = 1'b0;
      if (i != n - 1 || !done_last) tick();
    end
    if (!done_last) begin
      bus.fc_done = 1'b1;
      tick();
      bus.fc_done = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] id, input logic [15:0] score,
                              input logic e);
    chk({tag, "_valid"}, {bus.class_valid, bus.act_ready}, 32'b10);
    chk({tag, "_id"}, 32'(bus.class_id), 32'(id));
    chk({tag, "_score"}, 32'(bus.class_score), 32'(score));
    chk({tag, "_err"}, 32'(err), 32'(e));
  endtask

  task automatic accept();
    bus.class_ready = 1'b1;
    tick();
    bus.class_ready = 1'b0;
    chk("accept", {bus.act_ready, bus.class_valid, busy}, 32'b100);
  endtask

  initial begin
    reset            = 1'b1;
    bus.act_data     = '0;
    bus.act_valid    = 1'b0;
    bus.fc_out_data  = '0;
    bus.fc_out_valid = 1'b0;
    bus.fc_done      = 1'b0;
    bus.class_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state();

    // Test 1: basic argmax; fc_done coincides with the last logit.
    lg = '{16'd5, 16'hFFFD, 16'd100, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    send_frame(16'h0100);
    replay_check(16'h0100);
    play(10, 1'b1);
    check_result("t1", 4'd2, 16'd100, 1'b0);
    // layer strobes outside WAIT must not disturb the held result
    bus.fc_out_valid = 1'b1;
    bus.fc_out_data  = 16'h7FFF;
    bus.fc_done      = 1'b1;
    tick();
    bus.fc_out_valid = 1'b0;
    bus.fc_done      = 1'b0;
    check_result("t1_ignore", 4'd2, 16'd100, 1'b0);
    accept();

    // Test 2: tie keeps the lowest index; separate fc_done.
    lg = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h0040, 16'hFFFB,
           16'hFFFA, 16'hFFF9, 16'hFFF8, 16'h0040, 16'hFFF7};
    send_frame(16'h0200);
    replay_check(16'h0200);
    play(10, 1'b0);
    check_result("t2", 4'd3, 16'h0040, 1'b0);
    accept();

    // Tests 3+4: all negative logits, then back-pressure on the result.
    lg = '{16'hFFF6, 16'hFFFE, 16'hFFF7, 16'hFFEC, 16'hFFE2,
           16'hFFD8, 16'hFFF1, 16'hFFE7, 16'hFFDD, 16'hFFCE};
    send_frame(16'h0300);
    replay_check(16'h0300);
    play(10, 1'b0);
    check_result("t3", 4'd1, 16'hFFFE, 1'b0);
    bus.act_valid = 1'b1;
    bus.act_data  = 16'hABCD;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_hold", {bus.class_valid, bus.act_ready, bus.class_id, bus.class_score},
          {10'd0, 1'b1, 1'b0, 4'd1, 16'hFFFE});
    end
    bus.act_valid = 1'b0;
    accept();

    // Test 5: reset while word 12 is being replayed.
    send_frame(16'h0400);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_word12", {bus.fc_in_valid, bus.fc_in_data}, {15'd0, 1'b1, 16'h040C});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state();
    lg = '{16'd5, 16'hFFFD, 16'd100, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    send_frame(16'h0500);
    replay_check(16'h0500);
    play(10, 1'b1);
    check_result("t5_after", 4'd2, 16'd100, 1'b0);
    accept();

`ifdef FC2_WATCHDOG_EN
    // Watchdog: fc_done withheld, no logits at all.
    send_frame(16'h0600);
    replay_check(16'h0600);
    for (int c = 0; c < 1100 && !bus.class_valid; c++) tick();
    check_result("wd", 4'd0, 16'd0, 1'b1);
    accept();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state();
`endif

    // Test 6: only 9 logits before fc_done -> err, result still delivered.
    lg = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd0};
    send_frame(16'h0700);
    replay_check(16'h0700);
    play(9, 1'b0);
    check_result("t6", 4'd8, 16'd9, 1'b1);
    accept();
    chk("t6_err_sticky", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
